// File: rtl/pixel_ram_pkg.sv
// Shared constants and types for the pixel RAM arbiter: default widths,
// arbiter state encoding and the renderer write entry.
package pixel_ram_pkg;

    localparam int PIX_ADDR_W     = 10;
    localparam int PIX_DATA_W     = 8;
    localparam int PIX_FIFO_DEPTH = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [PIX_ADDR_W-1:0] addr;
        logic [PIX_DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/pixel_ram_arbiter_if.sv
// Display-read and renderer-write bus between the video front end (master)
// and the pixel RAM arbiter (slave).
interface pixel_ram_arbiter_if
    import pixel_ram_pkg::*;
#(
    parameter int ADDR_W = PIX_ADDR_W,
    parameter int DATA_W = PIX_DATA_W
) ();

    // Reads have no backpressure: rd_valid/rd_data follow rd_req by one cycle.
    // Writes transfer on a rising edge with wr_valid && wr_ready; the master
    // holds wr_valid, wr_addr and wr_data stable until that edge.
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data,
        input  rd_data, rd_valid, wr_ready
    );

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data,
        output rd_data, rd_valid, wr_ready
    );

endinterface

// File: rtl/pixel_wr_fifo.sv
// Synchronous write queue for renderer pixels; flush drops all entries,
// including a push presented in the same cycle.
module pixel_wr_fifo #(
    parameter  int W     = 18,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/pixel_ram_arbiter.sv
// Single-port pixel RAM arbiter: display reads always win, then buffer-clear
// writes, then queued renderer writes; one RAM access per cycle.
module pixel_ram_arbiter
    import pixel_ram_pkg::*;
#(
    parameter int ADDR_W     = PIX_ADDR_W,
    parameter int DATA_W     = PIX_DATA_W,
    parameter int FIFO_DEPTH = PIX_FIFO_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    pixel_ram_arbiter_if.slave                bus,
    input  logic                              clear_start_i,
    input  logic [DATA_W-1:0]                 clear_color_i,
    output logic                              clear_busy_o,
    output logic                              clear_done_o,
    output logic [ADDR_W-1:0]                 ram_addr_o,
    output logic                              ram_we_o,
    output logic [DATA_W-1:0]                 ram_wdata_o,
    input  logic [DATA_W-1:0]                 ram_rdata_i,
    output arb_state_e                        state_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o
);

    arb_state_e               state_q, state_d;
    logic [ADDR_W-1:0]        clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]        clr_col_q, clr_col_d;
    logic                     clr_done_q, clr_done_d;
    logic                     rd_valid_q;
    logic                     fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
    logic [ADDR_W+DATA_W-1:0] fifo_head;

    // wr_ready depends only on registered state, never on rd_req.
    assign bus.wr_ready = !rst && !fifo_full && (state_q == IDLE);
    assign fifo_push    = bus.wr_valid && bus.wr_ready;

    pixel_wr_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i ({bus.wr_addr, bus.wr_data}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_o)
    );

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        clr_col_d   = clr_col_q;
        clr_done_d  = 1'b0;
        fifo_flush  = 1'b0;
        fifo_pop    = 1'b0;
        ram_addr_o  = bus.rd_req ? bus.rd_addr : '0;
        ram_we_o    = 1'b0;
        ram_wdata_o = '0;
        unique case (state_q)
            IDLE: begin
                if (clear_start_i) begin
                    state_d    = CLEAR;
                    clr_cnt_d  = '0;
                    clr_col_d  = clear_color_i;
                    fifo_flush = 1'b1;
                end else if (!bus.rd_req && !fifo_empty) begin
                    fifo_pop    = 1'b1;
                    ram_we_o    = 1'b1;
                    ram_addr_o  = fifo_head[ADDR_W+DATA_W-1:DATA_W];
                    ram_wdata_o = fifo_head[DATA_W-1:0];
                end
            end
            CLEAR: begin
                // A new clear_start abandons the current pass without a done pulse.
                if (clear_start_i) begin
                    clr_cnt_d  = '0;
                    clr_col_d  = clear_color_i;
                    fifo_flush = 1'b1;
                end else if (!bus.rd_req) begin
                    ram_we_o    = 1'b1;
                    ram_addr_o  = clr_cnt_q;
                    ram_wdata_o = clr_col_q;
                    clr_cnt_d   = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == '1) begin
                        state_d    = IDLE;
                        clr_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            ram_addr_o  = '0;
            ram_we_o    = 1'b0;
            ram_wdata_o = '0;
            fifo_pop    = 1'b0;
            fifo_flush  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            clr_col_q  <= '0;
            clr_done_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_col_q  <= clr_col_d;
            clr_done_q <= clr_done_d;
            rd_valid_q <= bus.rd_req;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_valid_q ? ram_rdata_i : '0;
    assign clear_busy_o = (state_q == CLEAR) && !rst;
    assign clear_done_o = clr_done_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// Directed self-checking bench for pixel_ram_arbiter with a behavioural
// synchronous single-port RAM.
module tb_pixel_ram_arbiter;
  import pixel_ram_pkg::*;

  localparam int AW     = PIX_ADDR_W;
  localparam int DW     = PIX_DATA_W;
  localparam int DEPTH  = PIX_FIFO_DEPTH;
  localparam int NWORDS = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pixel_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic                         clear_start, clear_busy, clear_done, ram_we;
  logic [DW-1:0]                clear_color, ram_wdata, ram_rdata;
  logic [AW-1:0]                ram_addr;
  arb_state_e                   state;
  logic [$clog2(DEPTH+1)-1:0]   fifo_count;

  pixel_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .clear_start_i (clear_start),
    .clear_color_i (clear_color),
    .clear_busy_o  (clear_busy),
    .clear_done_o  (clear_done),
    .ram_addr_o    (ram_addr),
    .ram_we_o      (ram_we),
    .ram_wdata_o   (ram_wdata),
    .ram_rdata_i   (ram_rdata),
    .state_o       (state),
    .fifo_count_o  (fifo_count)
  );

  // ---------------- RAM model and write monitor ----------------
  logic [DW-1:0]    mem [NWORDS];
  logic             tb_we;
  logic [AW-1:0]    tb_addr;
  logic [DW-1:0]    tb_data;
  logic [AW+DW-1:0] wlog [$];
  int               we_during_rd = 0;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (tb_we) mem[tb_addr] <= tb_data;
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (ram_we) begin
      wlog.push_back({ram_addr, ram_wdata});
      if (bus.rd_req) we_during_rd++;
    end
  end

  // ---------------- scoreboard ----------------
  int               n_checks = 0;
  int               n_errors = 0;
  logic [AW+DW-1:0] exp_q [$];
  wr_entry_t        wvec [5];
  wr_entry_t        wx;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    cycle();
    tb_we = 1'b0;
  endtask

  task automatic push_under_read(input wr_entry_t e, input logic exp_rdy);
    bus.rd_req = 1'b1; bus.rd_addr = AW'(5);
    bus.wr_valid = 1'b1; bus.wr_addr = e.addr; bus.wr_data = e.data;
    #1;
    check_eq("fill_wr_ready", bus.wr_ready, exp_rdy);
    check_eq("fill_no_we", ram_we, 1'b0);
    if (exp_rdy) exp_q.push_back(e);
    cycle();
  endtask

  task automatic drain_one();
    logic [AW+DW-1:0] e;
    bus.rd_req = 1'b0;
    #1;
    e = exp_q.pop_front();
    check_eq("drain_we", ram_we, 1'b1);
    check_eq("drain_entry", {ram_addr, ram_wdata}, e);
    cycle();
  endtask

  task automatic count_mem_not(input logic [DW-1:0] col, output int bad);
    bad = 0;
    for (int a = 0; a < NWORDS; a++) if (mem[a] !== col) bad++;
  endtask

  // Runs one clear from its clear_start cycle until clear_done (bounded).
  // Cycle n=1 is the first cycle after clear_start. With half_rd, rd_req is
  // high on odd cycles; clear writes then land on even cycles, so a read in
  // cycle n sees (n-1)/2 addresses already holding the new colour.
  task automatic run_clear(input logic [DW-1:0] color, input logic [DW-1:0] old_col,
                           input bit half_rd, input int restart_at, input logic [DW-1:0] color2,
                           output int busy_cnt, output int done_at, output int rd_bad);
    logic          prev_req;
    logic [DW-1:0] prev_exp;
    int            a;
    busy_cnt = 0; done_at = 0; rd_bad = 0; prev_req = 1'b0; prev_exp = '0;
    clear_color = color; clear_start = 1'b1; bus.rd_req = 1'b0; bus.wr_valid = 1'b0;
    #1;
    check_eq("clr_start_no_we", ram_we, 1'b0);
    cycle();
    clear_start = 1'b0;
    for (int n = 1; n <= 4000; n++) begin
      if (bus.rd_valid !== prev_req) rd_bad++;
      else if (prev_req && bus.rd_data !== prev_exp) rd_bad++;
      if (clear_done) begin
        done_at = n;
        break;
      end
      if (clear_busy) busy_cnt++;
      if (n == restart_at) begin
        clear_start = 1'b1; clear_color = color2;
      end
      a = (n * 37) % NWORDS;
      bus.rd_req  = half_rd && (n % 2 == 1);
      bus.rd_addr = AW'(a);
      prev_exp    = (a < (n - 1) / 2) ? color : old_col;
      prev_req    = bus.rd_req;
      cycle();
      clear_start = 1'b0;
    end
    bus.rd_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_cnt, done_at, rd_bad, bad, dn;

    wvec[0] = '{addr: 10'd100, data: 8'h11};
    wvec[1] = '{addr: 10'd203, data: 8'h22};
    wvec[2] = '{addr: 10'd306, data: 8'h33};
    wvec[3] = '{addr: 10'd409, data: 8'h44};
    wvec[4] = '{addr: 10'd512, data: 8'h55};
    wx      = '{addr: 10'd777, data: 8'h99};

    rst = 1'b1; clear_start = 1'b0; clear_color = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    cycle();

    // Reset state, including a read request that must not reach the RAM.
    bus.rd_req = 1'b1; bus.rd_addr = AW'(7);
    #1;
    check_eq("rst_wr_ready", bus.wr_ready, 1'b0);
    check_eq("rst_ram_we", ram_we, 1'b0);
    check_eq("rst_ram_addr", ram_addr, '0);
    check_eq("rst_ram_wdata", ram_wdata, '0);
    check_eq("rst_rd_valid", bus.rd_valid, 1'b0);
    check_eq("rst_rd_data", bus.rd_data, '0);
    check_eq("rst_clear_busy", clear_busy, 1'b0);
    check_eq("rst_clear_done", clear_done, 1'b0);
    check_eq("rst_state", state, IDLE);
    check_eq("rst_fifo_count", fifo_count, '0);
    bus.rd_req = 1'b0;
    preload(AW'(5), 8'hE3);
    preload(AW'(6), 8'h5A);
    rst = 1'b0;
    #1;
    check_eq("post_rst_wr_ready", bus.wr_ready, 1'b1);
    check_eq("post_rst_rd_valid", bus.rd_valid, 1'b0);

    // Continuous display reads: granted every cycle, data one cycle later.
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] a;
      a = (i % 2 == 1) ? AW'(6) : AW'(5);
      bus.rd_req = 1'b1; bus.rd_addr = a;
      #1;
      check_eq("rd_no_we", ram_we, 1'b0);
      check_eq("rd_ram_addr", ram_addr, a);
      cycle();
      check_eq("rd_valid", bus.rd_valid, 1'b1);
      check_eq("rd_data", bus.rd_data, (i % 2 == 1) ? 8'h5A : 8'hE3);
    end
    bus.rd_req = 1'b0;
    cycle();
    check_eq("rd_valid_drop", bus.rd_valid, 1'b0);
    check_eq("rd_data_drop", bus.rd_data, '0);

    // Five writes under continuous reads: four accepted, then drained in order.
    for (int i = 0; i < 5; i++) push_under_read(wvec[i], i < 4);
    check_eq("fifo_count_full", fifo_count, 3'd4);
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) drain_one();
    #1;
    check_eq("drain_idle_we", ram_we, 1'b0);
    check_eq("drain_fifo_empty", fifo_count, '0);

    // Full FIFO with a simultaneous pop still refuses the push.
    for (int i = 0; i < 4; i++) push_under_read(wvec[i], 1'b1);
    bus.wr_valid = 1'b1; bus.wr_addr = wx.addr; bus.wr_data = wx.data;
    bus.rd_req = 1'b0;
    #1;
    check_eq("full_pop_wr_ready", bus.wr_ready, 1'b0);
    drain_one();
    check_eq("after_pop_wr_ready", bus.wr_ready, 1'b1);
    exp_q.push_back(wx);
    drain_one();
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) drain_one();
    #1;
    check_eq("full_pop_idle_we", ram_we, 1'b0);
    check_eq("we_during_rd_writes", we_during_rd, 0);

    // Full clear with no reads.
    wlog.delete();
    run_clear(8'h1C, 8'h00, 1'b0, 0, 8'h00, busy_cnt, done_at, rd_bad);
    check_eq("clr_busy_cycles", busy_cnt, 1024);
    check_eq("clr_done_cycle", done_at, 1025);
    check_eq("clr_done_state", state, IDLE);
    check_eq("clr_wlog_size", wlog.size(), 1024);
    bad = 0;
    for (int i = 0; i < 1024 && i < wlog.size(); i++)
      if (wlog[i] !== {AW'(i), 8'h1C}) bad++;
    check_eq("clr_write_order", bad, 0);
    count_mem_not(8'h1C, bad);
    check_eq("clr_fill", bad, 0);
    cycle();
    check_eq("clr_done_pulse", clear_done, 1'b0);
    check_eq("clr_idle_wr_ready", bus.wr_ready, 1'b1);

    // Clear interleaved with reads on alternate cycles.
    run_clear(8'h63, 8'h1C, 1'b1, 0, 8'h00, busy_cnt, done_at, rd_bad);
    check_eq("half_busy_cycles", busy_cnt, 2048);
    check_eq("half_done_cycle", done_at, 2049);
    check_eq("half_reads_ok", rd_bad, 0);
    check_eq("half_we_during_rd", we_during_rd, 0);
    count_mem_not(8'h63, bad);
    check_eq("half_fill", bad, 0);
    cycle();

    // Queued writes flushed by clear_start; restart at counter 300.
    push_under_read('{addr: 10'd10, data: 8'h01}, 1'b1);
    push_under_read('{addr: 10'd20, data: 8'h02}, 1'b1);
    exp_q.delete();
    check_eq("queued_count", fifo_count, 3'd2);
    wlog.delete();
    run_clear(8'h55, 8'h00, 1'b0, 301, 8'hAA, busy_cnt, done_at, rd_bad);
    check_eq("restart_busy_cycles", busy_cnt, 1325);
    check_eq("restart_done_cycle", done_at, 1326);
    bad = 0;
    foreach (wlog[i]) if (wlog[i][DW-1:0] !== 8'h55 && wlog[i][DW-1:0] !== 8'hAA) bad++;
    check_eq("restart_no_queued_writes", bad, 0);
    bad = 0;
    if (wlog.size() < 1024) bad = 1024;
    else for (int i = 0; i < 1024; i++)
      if (wlog[wlog.size() - 1024 + i] !== {AW'(i), 8'hAA}) bad++;
    check_eq("restart_write_order", bad, 0);
    count_mem_not(8'hAA, bad);
    check_eq("restart_fill", bad, 0);
    cycle();
    check_eq("restart_fifo_empty", fifo_count, '0);
    check_eq("restart_idle_we", ram_we, 1'b0);

    // Reset at clear counter 600 aborts without clear_done.
    clear_color = 8'h3C; clear_start = 1'b1;
    cycle();
    clear_start = 1'b0;
    for (int i = 0; i < 600; i++) cycle();
    check_eq("abort_busy_before", clear_busy, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("abort_rst_we", ram_we, 1'b0);
    check_eq("abort_rst_wr_ready", bus.wr_ready, 1'b0);
    cycle();
    rst = 1'b0;
    #1;
    check_eq("abort_busy_after", clear_busy, 1'b0);
    check_eq("abort_state", state, IDLE);
    check_eq("abort_wr_ready", bus.wr_ready, 1'b1);
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      if (clear_done) dn++;
      cycle();
    end
    check_eq("abort_no_done", dn, 0);
    check_eq("abort_mem_599", mem[599], 8'h3C);
    check_eq("abort_mem_600", mem[600], 8'hAA);
    check_eq("abort_mem_1023", mem[1023], 8'hAA);
    check_eq("final_we_during_rd", we_during_rd, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
